// File: rtl/l0_ififo_pkg.sv
// Shared sizing constants for the L0 input FIFO slice.
package l0_ififo_pkg;

  localparam int unsigned ROW      = 8;
  localparam int unsigned BW       = 4;
  localparam int unsigned L0_DEPTH = 64;
  localparam int unsigned PTR_W    = $clog2(L0_DEPTH) + 1;

endpackage

// File: rtl/l0_ififo_if.sv
// Write/read handshake and lane data bus of the L0 input FIFO.
interface l0_ififo_if
  import l0_ififo_pkg::*;
#(
  parameter int unsigned row = ROW,
  parameter int unsigned bw  = BW
);

  logic                wr;
  logic                rd;
  logic [row*bw-1:0]   in;
  logic [row*bw-1:0]   out;
  logic                o_full;
  logic                o_ready;
  logic [row-1:0]      o_valid;

  modport master (
    output wr, rd, in,
    input  out, o_full, o_ready, o_valid
  );

  modport slave (
    input  wr, rd, in,
    output out, o_full, o_ready, o_valid
  );

endinterface

// File: rtl/l0_ififo_lane.sv
// Single-lane FIFO with extra-MSB pointers and a registered output.
module l0_lane_fifo #(
  parameter int unsigned bw    = 4,
  parameter int unsigned depth = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] in,
  output logic [bw-1:0] out,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_valid
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [bw-1:0] r_mem [depth];
  logic [bw-1:0] r_out;
  logic          r_valid;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = wr & ~o_full;
  assign w_pop   = rd & ~o_empty;
  assign out     = r_out;
  assign o_valid = r_valid;

  // Pointer, output and valid update; full/empty come from pre-edge pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_valid <= w_pop;
      if (w_pop) begin
        r_out    <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents are not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in;
  end

endmodule

// File: rtl/l0_ififo.sv
// Row-wide input FIFO feeding the array west edge with a diagonal read skew.
module l0_ififo
  import l0_ififo_pkg::*;
#(
  parameter int unsigned row   = ROW,
  parameter int unsigned bw    = BW,
  parameter int unsigned depth = L0_DEPTH
) (
  input logic        clk,
  input logic        reset,
  l0_ififo_if.slave  bus
);

  logic [row-1:0]    r_rd_en;
  logic [row-1:0]    w_full;
  logic [row-1:0]    w_empty;
  logic [row-1:0]    w_valid;
  logic [row*bw-1:0] w_out;
  logic              w_full_any;
  logic              w_wr;

  assign w_full_any  = |w_full;
  assign w_wr        = bus.wr & ~w_full_any;
  assign bus.o_full  = w_full_any;
  assign bus.o_ready = ~w_full_any;
  assign bus.o_valid = w_valid;
  assign bus.out     = w_out;

  // Skew shift register: lane i pops i cycles after lane 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_en <= '0;
    else       r_rd_en <= {r_rd_en[row-2:0], bus.rd};
  end

  for (genvar gi = 0; gi < row; gi++) begin : g_lane
    l0_lane_fifo #(
      .bw    (bw),
      .depth (depth)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr      (w_wr),
      .rd      (r_rd_en[gi] & ~w_empty[gi]),
      .in      (bus.in[bw*gi +: bw]),
      .out     (w_out[bw*gi +: bw]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_valid (w_valid[gi])
    );
  end

endmodule
